// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX/MEM hazard inputs and stall/flush/forward outputs of hazard_ctrl
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_id_valid;
  logic [4:0]       i_id_rs1_addr;
  logic [4:0]       i_id_rs2_addr;
  logic             i_id_use_rs1;
  logic             i_id_use_rs2;
  logic [4:0]       i_id_rd_addr;
  logic             i_id_rd_wren;
  logic             i_id_mem_load;
  logic             i_ex_redirect;
  logic             i_dmem_wait;
  logic             i_cnt_clr;
  logic             o_stall_if;
  logic             o_stall_id;
  logic             o_stall_ex;
  logic             o_stall_mem;
  logic             o_flush_id;
  logic             o_flush_ex;
  logic [1:0]       o_fwd_a_sel;
  logic [1:0]       o_fwd_b_sel;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport slave (
    input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_use_rs1, i_id_use_rs2,
           i_id_rd_addr, i_id_rd_wren, i_id_mem_load, i_ex_redirect, i_dmem_wait, i_cnt_clr,
    output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_flush_id, o_flush_ex,
           o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
  );

  modport master (
    output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_use_rs1, i_id_use_rs2,
           i_id_rd_addr, i_id_rd_wren, i_id_mem_load, i_ex_redirect, i_dmem_wait, i_cnt_clr,
    input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_flush_id, o_flush_ex,
           o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage RV32I hazard controller: stalls, flushes, EX forwarding, perf counters
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  hazard_ctrl_if.slave  bus
);
  logic             ex_valid_q, ex_wren_q, ex_load_q;
  logic [4:0]       ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic             mem_valid_q, mem_wren_q, mem_load_q;
  logic [4:0]       mem_rd_q;
  logic             wb_valid_q, wb_wren_q;
  logic [4:0]       wb_rd_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
  logic load_use;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic hit(input logic v, input logic wren, input logic [4:0] rd,
                               input logic [4:0] r);
    return v & wren & (rd != 5'd0) & (rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic m_v, input logic m_w,
                                         input logic [4:0] m_rd, input logic m_ld,
                                         input logic w_v, input logic w_w, input logic [4:0] w_rd);
    if (hit(m_v, m_w, m_rd, r) && !m_ld) return 2'b01;
    else if (hit(w_v, w_w, w_rd, r))     return 2'b10;
    else                                 return 2'b00;
  endfunction

  assign load_use = bus.i_id_valid & ex_load_q &
                    ((bus.i_id_use_rs1 & hit(ex_valid_q, ex_wren_q, ex_rd_q, bus.i_id_rs1_addr)) |
                     (bus.i_id_use_rs2 & hit(ex_valid_q, ex_wren_q, ex_rd_q, bus.i_id_rs2_addr)));

  // Reset gates the controls so nothing leaks out while the core is held in reset.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    if (!i_reset) begin
      if (bus.i_dmem_wait) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (bus.i_ex_redirect) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid_q && !i_reset) begin
      fwd_a = fwd_sel(ex_rs1_q, mem_valid_q, mem_wren_q, mem_rd_q, mem_load_q,
                      wb_valid_q, wb_wren_q, wb_rd_q);
      fwd_b = fwd_sel(ex_rs2_q, mem_valid_q, mem_wren_q, mem_rd_q, mem_load_q,
                      wb_valid_q, wb_wren_q, wb_rd_q);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.i_cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_id && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_id && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_valid_q  <= 1'b0;
      ex_wren_q   <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      ex_rd_q     <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_load_q  <= 1'b0;
      mem_rd_q    <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_wren_q   <= 1'b0;
      wb_rd_q     <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (!bus.i_dmem_wait) begin
        wb_valid_q  <= mem_valid_q;
        wb_wren_q   <= mem_wren_q;
        wb_rd_q     <= mem_rd_q;
        mem_valid_q <= ex_valid_q;
        mem_wren_q  <= ex_wren_q;
        mem_load_q  <= ex_load_q;
        mem_rd_q    <= ex_rd_q;
        ex_valid_q  <= bus.i_id_valid & ~flush_ex;
        ex_wren_q   <= bus.i_id_rd_wren;
        ex_load_q   <= bus.i_id_mem_load;
        ex_rs1_q    <= bus.i_id_rs1_addr;
        ex_rs2_q    <= bus.i_id_rs2_addr;
        ex_rd_q     <= bus.i_id_rd_addr;
      end
    end
  end

  assign bus.o_stall_if  = stall_if;
  assign bus.o_stall_id  = stall_id;
  assign bus.o_stall_ex  = stall_ex;
  assign bus.o_stall_mem = stall_mem;
  assign bus.o_flush_id  = flush_id;
  assign bus.o_flush_ex  = flush_ex;
  assign bus.o_fwd_a_sel = fwd_a;
  assign bus.o_fwd_b_sel = fwd_b;
  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;
endmodule
